// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap arbiter:
// CSR addresses, exception codes, mstatus bit positions and field-masking helpers.
package csr_trap_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned CNT_W   = 64;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MTIMECMP = 12'h7C0;
  localparam logic [CSR_AW-1:0] CSR_MTIMECMPH= 12'h7C1;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] EXC_NONE        = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_ILLEGAL     = 32'h0000_0002;
  localparam logic [XLEN-1:0] EXC_EBREAK      = 32'h0000_0003;
  localparam logic [XLEN-1:0] EXC_LD_MISALIGN = 32'h0000_0004;
  localparam logic [XLEN-1:0] EXC_ST_MISALIGN = 32'h0000_0006;
  localparam logic [XLEN-1:0] EXC_MRET        = 32'h0000_000a;
  localparam logic [XLEN-1:0] EXC_ECALL       = 32'h0000_000b;
  localparam logic [XLEN-1:0] EXC_TIMER_IRQ   = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MIE_MTIE       = 7;
  localparam int unsigned MIP_MTIP       = 7;

  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;
  localparam logic            RST_ENABLE = 1'b0;

  typedef struct packed {
    logic illegal;
    logic ebreak;
    logic ecall;
    logic ld_misalign;
    logic st_misalign;
    logic mret;
  } exc_flags_t;

  // mstatus as software sees it: MPP hard-wired to machine mode
  function automatic logic [XLEN-1:0] mstatus_view(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v = '0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    v[MSTATUS_MPIE] = mpie;
    v[MSTATUS_MIE]  = mie;
    return v;
  endfunction

  function automatic logic csr_writable(input logic [CSR_AW-1:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MTIMECMP, CSR_MTIMECMPH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Value a write would leave visible in the addressed CSR
  function automatic logic [XLEN-1:0] csr_wmask(input logic [CSR_AW-1:0] addr,
                                                input logic [XLEN-1:0]   wdata);
    logic [XLEN-1:0] m;
    m = wdata;
    case (addr)
      CSR_MSTATUS: m = mstatus_view(wdata[MSTATUS_MIE], wdata[MSTATUS_MPIE]);
      CSR_MIE: begin
        m = '0;
        m[MIE_MTIE] = wdata[MIE_MTIE];
      end
      CSR_MTVEC, CSR_MEPC: m = wdata & ~32'h3;
      default: m = wdata;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/csr_trap_unit_counter.sv
// 64-bit mcycle counter with independent half writes, the mtimecmp register
// and the timer-pending compare.
module csr_trap_unit_counter
  import csr_trap_unit_pkg::*;
#(
  parameter logic [CNT_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cycle_we_lo,
  input  logic               cycle_we_hi,
  input  logic               cmp_we_lo,
  input  logic               cmp_we_hi,
  input  logic [XLEN-1:0]    wdata,
  output logic [CNT_W-1:0]   mcycle,
  output logic [CNT_W-1:0]   mtimecmp,
  output logic               mtip_c
);

  logic [CNT_W-1:0] cycle_inc;

  assign cycle_inc = mcycle + 64'd1;
  assign mtip_c    = (mcycle >= mtimecmp);

  // Written half loads; the other half keeps counting, carry included
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mcycle   <= '0;
      mtimecmp <= MTIMECMP_RST;
    end else begin
      mcycle <= {cycle_we_hi ? wdata : cycle_inc[63:32],
                 cycle_we_lo ? wdata : cycle_inc[31:0]};
      if (cmp_we_lo) mtimecmp[31:0]  <= wdata;
      if (cmp_we_hi) mtimecmp[63:32] <= wdata;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap arbiter: prioritises MEM-stage exceptions and
// the timer interrupt, commits trap state and serves forwarded CSR reads.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [XLEN-1:0]  MTVEC_RST    = 32'h0000_0000,
  parameter int unsigned      HART_ID      = 0,
  parameter logic [CNT_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CSR_AW-1:0] csr_raddr_i,
  output logic [XLEN-1:0]   csr_rdata_o,
  input  logic              csr_we_i,
  input  logic [CSR_AW-1:0] csr_waddr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              mem_inst_valid_i,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic [XLEN-1:0]   mem_badaddr_i,
  input  logic              mem_illegal_i,
  input  logic              mem_ebreak_i,
  input  logic              mem_ecall_i,
  input  logic              mem_ld_misalign_i,
  input  logic              mem_st_misalign_i,
  input  logic              mem_mret_i,
  output logic [XLEN-1:0]   excepttype_o,
  output logic [XLEN-1:0]   csr_mepc_o,
  output logic [XLEN-1:0]   csr_mtvec_o
);

  logic             mie_q, mpie_q, mtie_q;
  logic [XLEN-1:0]  mtvec_q, mepc_q, mscratch_q, mcause_q, mtval_q;
  logic [CNT_W-1:0] mcycle, mtimecmp;
  logic             mtip_c, irq_c, trap_c, mret_c;
  logic             wb_mstatus_c, mie_eff_c, mpie_eff_c;
  logic [XLEN-1:0]  rd_reg_c;
  exc_flags_t       flags;

  assign flags.illegal     = mem_illegal_i;
  assign flags.ebreak      = mem_ebreak_i;
  assign flags.ecall       = mem_ecall_i;
  assign flags.ld_misalign = mem_ld_misalign_i;
  assign flags.st_misalign = mem_st_misalign_i;
  assign flags.mret        = mem_mret_i;

  csr_trap_unit_counter #(.MTIMECMP_RST(MTIMECMP_RST)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .cycle_we_lo (csr_we_i && (csr_waddr_i == CSR_MCYCLE)),
    .cycle_we_hi (csr_we_i && (csr_waddr_i == CSR_MCYCLEH)),
    .cmp_we_lo   (csr_we_i && (csr_waddr_i == CSR_MTIMECMP)),
    .cmp_we_hi   (csr_we_i && (csr_waddr_i == CSR_MTIMECMPH)),
    .wdata       (csr_wdata_i),
    .mcycle      (mcycle),
    .mtimecmp    (mtimecmp),
    .mtip_c      (mtip_c)
  );

  assign irq_c = mie_q & mtie_q & mtip_c & mem_inst_valid_i;

  // Fixed-priority exception arbitration, held at zero during reset
  always_comb begin
    excepttype_o = EXC_NONE;
    if (rst != RST_ENABLE) begin
      if (irq_c)                    excepttype_o = EXC_TIMER_IRQ;
      else if (!mem_inst_valid_i)   excepttype_o = EXC_NONE;
      else if (flags.illegal)       excepttype_o = EXC_ILLEGAL;
      else if (flags.ebreak)        excepttype_o = EXC_EBREAK;
      else if (flags.ecall)         excepttype_o = EXC_ECALL;
      else if (flags.ld_misalign)   excepttype_o = EXC_LD_MISALIGN;
      else if (flags.st_misalign)   excepttype_o = EXC_ST_MISALIGN;
      else if (flags.mret)          excepttype_o = EXC_MRET;
    end
  end

  assign mret_c = (excepttype_o == EXC_MRET);
  assign trap_c = (excepttype_o != EXC_NONE) && !mret_c;

  // The older WB write to mstatus lands before the trap/mret swap reads it
  assign wb_mstatus_c = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
  assign mie_eff_c    = wb_mstatus_c ? csr_wdata_i[MSTATUS_MIE]  : mie_q;
  assign mpie_eff_c   = wb_mstatus_c ? csr_wdata_i[MSTATUS_MPIE] : mpie_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ~32'h3;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (csr_we_i) begin
        case (csr_waddr_i)
          CSR_MSTATUS: begin
            mie_q  <= csr_wdata_i[MSTATUS_MIE];
            mpie_q <= csr_wdata_i[MSTATUS_MPIE];
          end
          CSR_MIE:      mtie_q     <= csr_wdata_i[MIE_MTIE];
          CSR_MTVEC:    mtvec_q    <= csr_wdata_i & ~32'h3;
          CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
          CSR_MEPC:     mepc_q     <= csr_wdata_i & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
          CSR_MTVAL:    mtval_q    <= csr_wdata_i;
          default: ;
        endcase
      end
      if (trap_c) begin
        mepc_q   <= mem_pc_i & ~32'h3;
        mcause_q <= excepttype_o;
        mtval_q  <= ((excepttype_o == EXC_ILLEGAL) || (excepttype_o == EXC_LD_MISALIGN) ||
                     (excepttype_o == EXC_ST_MISALIGN)) ? mem_badaddr_i : '0;
        mpie_q   <= mie_eff_c;
        mie_q    <= 1'b0;
      end else if (mret_c) begin
        mie_q  <= mpie_eff_c;
        mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_reg_c = '0;
    case (csr_raddr_i)
      CSR_MSTATUS:   rd_reg_c = mstatus_view(mie_q, mpie_q);
      CSR_MISA:      rd_reg_c = MISA_VALUE;
      CSR_MIE:       rd_reg_c[MIE_MTIE] = mtie_q;
      CSR_MTVEC:     rd_reg_c = mtvec_q;
      CSR_MSCRATCH:  rd_reg_c = mscratch_q;
      CSR_MEPC:      rd_reg_c = mepc_q;
      CSR_MCAUSE:    rd_reg_c = mcause_q;
      CSR_MTVAL:     rd_reg_c = mtval_q;
      CSR_MIP:       rd_reg_c[MIP_MTIP] = mtip_c;
      CSR_MCYCLE:    rd_reg_c = mcycle[31:0];
      CSR_MCYCLEH:   rd_reg_c = mcycle[63:32];
      CSR_MTIMECMP:  rd_reg_c = mtimecmp[31:0];
      CSR_MTIMECMPH: rd_reg_c = mtimecmp[63:32];
      CSR_MHARTID:   rd_reg_c = 32'(HART_ID);
      default:       rd_reg_c = '0;
    endcase
  end

  // Same-cycle WB writes bypass the registers
  assign csr_rdata_o = (csr_we_i && (csr_waddr_i == csr_raddr_i) && csr_writable(csr_raddr_i))
                       ? csr_wmask(csr_raddr_i, csr_wdata_i) : rd_reg_c;
  assign csr_mepc_o  = (csr_we_i && (csr_waddr_i == CSR_MEPC))  ? (csr_wdata_i & ~32'h3) : mepc_q;
  assign csr_mtvec_o = (csr_we_i && (csr_waddr_i == CSR_MTVEC)) ? (csr_wdata_i & ~32'h3) : mtvec_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus randomized
// traffic compared against an architectural model of the CSR state.
module tb_csr_trap_unit;

  localparam logic [31:0] TB_MTVEC_RST = 32'h8000_0100;
  localparam int unsigned TB_HART_ID   = 3;

  logic        clk, rst;
  logic [11:0] csr_raddr_i, csr_waddr_i;
  logic [31:0] csr_rdata_o, csr_wdata_i;
  logic        csr_we_i, mem_inst_valid_i;
  logic [31:0] mem_pc_i, mem_badaddr_i;
  logic        mem_illegal_i, mem_ebreak_i, mem_ecall_i;
  logic        mem_ld_misalign_i, mem_st_misalign_i, mem_mret_i;
  logic [31:0] excepttype_o, csr_mepc_o, csr_mtvec_o;

  int compared = 0;
  int mismatched = 0;

  csr_trap_unit #(.MTVEC_RST(TB_MTVEC_RST), .HART_ID(TB_HART_ID)) dut (
    .clk(clk), .rst(rst),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .mem_inst_valid_i(mem_inst_valid_i), .mem_pc_i(mem_pc_i), .mem_badaddr_i(mem_badaddr_i),
    .mem_illegal_i(mem_illegal_i), .mem_ebreak_i(mem_ebreak_i), .mem_ecall_i(mem_ecall_i),
    .mem_ld_misalign_i(mem_ld_misalign_i), .mem_st_misalign_i(mem_st_misalign_i),
    .mem_mret_i(mem_mret_i),
    .excepttype_o(excepttype_o), .csr_mepc_o(csr_mepc_o), .csr_mtvec_o(csr_mtvec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state of the hart's machine CSRs
  typedef struct {
    logic        mie, mpie, mtie;
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0] mcycle, mtimecmp;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.mie = 0; s.mpie = 0; s.mtie = 0;
    s.mtvec = TB_MTVEC_RST; s.mscratch = 0; s.mepc = 0; s.mcause = 0; s.mtval = 0;
    s.mcycle = 0; s.mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    return s;
  endfunction

  function automatic mstate_t apply_wb(mstate_t s, logic [11:0] a, logic [31:0] d);
    mstate_t r = s;
    case (a)
      12'h300: begin r.mie = d[3]; r.mpie = d[7]; end
      12'h304: r.mtie = d[7];
      12'h305: r.mtvec = {d[31:2], 2'b00};
      12'h340: r.mscratch = d;
      12'h341: r.mepc = {d[31:2], 2'b00};
      12'h342: r.mcause = d;
      12'h343: r.mtval = d;
      12'hB00: r.mcycle[31:0] = d;
      12'hB80: r.mcycle[63:32] = d;
      12'h7C0: r.mtimecmp[31:0] = d;
      12'h7C1: r.mtimecmp[63:32] = d;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] view(mstate_t s, logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (s.mpie ? 32'h80 : 0) + (s.mie ? 32'h8 : 0);
      12'h301: return 32'h4000_0100;
      12'h304: return s.mtie ? 32'h80 : 32'h0;
      12'h305: return s.mtvec;
      12'h340: return s.mscratch;
      12'h341: return s.mepc;
      12'h342: return s.mcause;
      12'h343: return s.mtval;
      12'h344: return (s.mcycle >= s.mtimecmp) ? 32'h80 : 32'h0;
      12'hB00: return s.mcycle[31:0];
      12'hB80: return s.mcycle[63:32];
      12'h7C0: return s.mtimecmp[31:0];
      12'h7C1: return s.mtimecmp[63:32];
      12'hF14: return 32'(TB_HART_ID);
      default: return 32'h0;
    endcase
  endfunction

  function automatic mstate_t visible();
    return csr_we_i ? apply_wb(m, csr_waddr_i, csr_wdata_i) : m;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (csr_raddr_i == 12'h344) return view(m, csr_raddr_i);
    return view(visible(), csr_raddr_i);
  endfunction

  function automatic logic [31:0] exp_code();
    if (!rst) return 0;
    if (m.mie && m.mtie && (m.mcycle >= m.mtimecmp) && mem_inst_valid_i) return 32'h8000_0007;
    if (!mem_inst_valid_i) return 0;
    if (mem_illegal_i) return 2;
    if (mem_ebreak_i) return 3;
    if (mem_ecall_i) return 32'hb;
    if (mem_ld_misalign_i) return 4;
    if (mem_st_misalign_i) return 6;
    if (mem_mret_i) return 32'ha;
    return 0;
  endfunction

  task automatic model_commit();
    logic [31:0] code;
    logic [63:0] inc;
    mstate_t s;
    code = exp_code();
    inc = m.mcycle + 64'd1;
    s = visible();
    if (csr_we_i && csr_waddr_i == 12'hB00)      s.mcycle = {inc[63:32], csr_wdata_i};
    else if (csr_we_i && csr_waddr_i == 12'hB80) s.mcycle = {csr_wdata_i, inc[31:0]};
    else                                          s.mcycle = inc;
    if (code != 0 && code != 32'ha) begin
      s.mepc = {mem_pc_i[31:2], 2'b00};
      s.mcause = code;
      s.mtval = (code == 2 || code == 4 || code == 6) ? mem_badaddr_i : 32'h0;
      s.mpie = s.mie;
      s.mie = 1'b0;
    end else if (code == 32'ha) begin
      s.mie = s.mpie;
      s.mpie = 1'b1;
    end
    m = s;
  endtask

  task automatic idle();
    csr_we_i = 0; csr_waddr_i = 0; csr_wdata_i = 0; csr_raddr_i = 0;
    mem_inst_valid_i = 0; mem_pc_i = 0; mem_badaddr_i = 0;
    mem_illegal_i = 0; mem_ebreak_i = 0; mem_ecall_i = 0;
    mem_ld_misalign_i = 0; mem_st_misalign_i = 0; mem_mret_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_commit();
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    wb_write(12'h341, 32'h0000_1234);
    tick();
    csr_raddr_i = 12'hB00; mem_inst_valid_i = 1; mem_ecall_i = 1;
    @(posedge clk);
    model_commit();
    #2 rst = 0;
    m = reset_state();
    #1;
    compared++;
    if (excepttype_o !== 32'h0) begin
      mismatched++; $display("FAIL reset_exc: got %h want 0", excepttype_o);
    end
    compared++;
    if (csr_mepc_o !== 32'h0) begin
      mismatched++; $display("FAIL reset_mepc: got %h want 0", csr_mepc_o);
    end
    compared++;
    if (csr_mtvec_o !== TB_MTVEC_RST) begin
      mismatched++; $display("FAIL reset_mtvec: got %h want %h", csr_mtvec_o, TB_MTVEC_RST);
    end
    compared++;
    if (csr_rdata_o !== 32'h0) begin
      mismatched++; $display("FAIL reset_rdata: got %h want 0", csr_rdata_o);
    end
    @(negedge clk);
    rst = 1;
    idle();
    csr_raddr_i = 12'h301;
    #1;
    compared++;
    if (csr_rdata_o !== 32'h4000_0100) begin
      mismatched++; $display("FAIL misa: got %h want 40000100", csr_rdata_o);
    end
    csr_raddr_i = 12'hF14;
    #1;
    compared++;
    if (csr_rdata_o !== 32'(TB_HART_ID)) begin
      mismatched++; $display("FAIL mhartid: got %h want %h", csr_rdata_o, 32'(TB_HART_ID));
    end
  endtask

  task automatic test_ecall();
    wb_write(12'h305, 32'h100);
    wb_write(12'h300, 32'h8);
    mem_inst_valid_i = 1; mem_ecall_i = 1; mem_pc_i = 32'h40;
    #1;
    compared++;
    if (excepttype_o !== 32'hb) begin
      mismatched++; $display("FAIL ecall_code: got %h want b", excepttype_o);
    end
    compared++;
    if (csr_mtvec_o !== 32'h100) begin
      mismatched++; $display("FAIL ecall_mtvec: got %h want 100", csr_mtvec_o);
    end
    tick();
    idle();
    csr_raddr_i = 12'h341; #1;
    compared++;
    if (csr_rdata_o !== 32'h40 || csr_mepc_o !== 32'h40) begin
      mismatched++; $display("FAIL ecall_mepc: got %h/%h want 40", csr_rdata_o, csr_mepc_o);
    end
    csr_raddr_i = 12'h342; #1;
    compared++;
    if (csr_rdata_o !== 32'hb) begin
      mismatched++; $display("FAIL ecall_mcause: got %h want b", csr_rdata_o);
    end
    csr_raddr_i = 12'h300; #1;
    compared++;
    if (csr_rdata_o !== 32'h1880) begin
      mismatched++; $display("FAIL ecall_mstatus: got %h want 1880", csr_rdata_o);
    end
  endtask

  task automatic test_mret_forward();
    idle();
    csr_we_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 32'h44;
    mem_inst_valid_i = 1; mem_mret_i = 1;
    #1;
    compared++;
    if (excepttype_o !== 32'ha) begin
      mismatched++; $display("FAIL mret_code: got %h want a", excepttype_o);
    end
    compared++;
    if (csr_mepc_o !== 32'h44) begin
      mismatched++; $display("FAIL mret_mepc_fwd: got %h want 44", csr_mepc_o);
    end
    tick();
    idle();
    csr_raddr_i = 12'h300; #1;
    compared++;
    if (csr_rdata_o !== 32'h1888) begin
      mismatched++; $display("FAIL mret_mstatus: got %h want 1888", csr_rdata_o);
    end
    compared++;
    if (csr_mepc_o !== 32'h44) begin
      mismatched++; $display("FAIL mret_mepc: got %h want 44", csr_mepc_o);
    end
  endtask

  task automatic test_timer();
    int waited = 0;
    wb_write(12'h7C1, 32'h0);
    wb_write(12'h7C0, 32'd20);
    wb_write(12'h304, 32'h80);
    wb_write(12'h300, 32'h8);
    while (m.mcycle < 64'd20 && waited < 200) begin
      tick();
      waited++;
    end
    compared++;
    if (waited >= 200) begin
      mismatched++; $display("FAIL timer_wait: mcycle %0d never reached 20", m.mcycle);
    end
    csr_raddr_i = 12'h344;
    mem_inst_valid_i = 1; mem_ld_misalign_i = 1; mem_pc_i = 32'h80; mem_badaddr_i = 32'h55;
    #1;
    compared++;
    if (excepttype_o !== 32'h8000_0007) begin
      mismatched++; $display("FAIL timer_code: got %h want 80000007", excepttype_o);
    end
    compared++;
    if (csr_rdata_o !== 32'h80) begin
      mismatched++; $display("FAIL timer_mip: got %h want 80", csr_rdata_o);
    end
    tick();
    idle();
    csr_raddr_i = 12'h343; #1;
    compared++;
    if (csr_rdata_o !== 32'h0 || csr_mepc_o !== 32'h80) begin
      mismatched++; $display("FAIL timer_state: mtval %h mepc %h want 0/80", csr_rdata_o, csr_mepc_o);
    end
    csr_raddr_i = 12'h342; #1;
    compared++;
    if (csr_rdata_o !== 32'h8000_0007) begin
      mismatched++; $display("FAIL timer_mcause: got %h want 80000007", csr_rdata_o);
    end
  endtask

  task automatic test_priority();
    idle();
    mem_illegal_i = 1; mem_ecall_i = 1; mem_st_misalign_i = 1;
    mem_badaddr_i = 32'hDEAD_BEEF; mem_pc_i = 32'h90;
    #1;
    compared++;
    if (excepttype_o !== 32'h0) begin
      mismatched++; $display("FAIL prio_bubble: got %h want 0", excepttype_o);
    end
    mem_inst_valid_i = 1;
    #1;
    compared++;
    if (excepttype_o !== 32'h2) begin
      mismatched++; $display("FAIL prio_code: got %h want 2", excepttype_o);
    end
    tick();
    idle();
    csr_raddr_i = 12'h343; #1;
    compared++;
    if (csr_rdata_o !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL prio_mtval: got %h want deadbeef", csr_rdata_o);
    end
  endtask

  task automatic test_counter();
    logic [31:0] hi_a;
    wb_write(12'hB00, 32'hFFFF_FFFF);
    hi_a = m.mcycle[63:32];
    csr_raddr_i = 12'hB00; #1;
    compared++;
    if (csr_rdata_o !== 32'hFFFF_FFFF) begin
      mismatched++; $display("FAIL cnt_lo_written: got %h want ffffffff", csr_rdata_o);
    end
    tick();
    csr_raddr_i = 12'hB00; #1;
    compared++;
    if (csr_rdata_o !== 32'h0) begin
      mismatched++; $display("FAIL cnt_lo_wrap: got %h want 0", csr_rdata_o);
    end
    csr_raddr_i = 12'hB80; #1;
    compared++;
    if (csr_rdata_o !== hi_a + 32'd1) begin
      mismatched++; $display("FAIL cnt_hi_carry: got %h want %h", csr_rdata_o, hi_a + 32'd1);
    end
  endtask

  task automatic test_random();
    logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'h7C0,
                               12'h7C1, 12'hF14, 12'h123, 12'h300};
    for (int i = 0; i < 400; i++) begin
      csr_we_i = ($urandom_range(0, 1) == 0);
      csr_waddr_i = pool[$urandom_range(0, 15)];
      csr_wdata_i = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 600)) : $urandom;
      if (csr_waddr_i == 12'hB80 || csr_waddr_i == 12'h7C1) csr_wdata_i = 32'($urandom_range(0, 1));
      csr_raddr_i = ($urandom_range(0, 3) == 0) ? csr_waddr_i : pool[$urandom_range(0, 15)];
      mem_inst_valid_i = ($urandom_range(0, 3) != 0);
      mem_pc_i = $urandom;
      mem_badaddr_i = $urandom;
      mem_illegal_i = ($urandom_range(0, 5) == 0);
      mem_ebreak_i = ($urandom_range(0, 5) == 0);
      mem_ecall_i = ($urandom_range(0, 5) == 0);
      mem_ld_misalign_i = ($urandom_range(0, 5) == 0);
      mem_st_misalign_i = ($urandom_range(0, 5) == 0);
      mem_mret_i = ($urandom_range(0, 3) == 0);
      #1;
      compared++;
      if (excepttype_o !== exp_code()) begin
        mismatched++; $display("FAIL rnd_exc[%0d]: got %h want %h", i, excepttype_o, exp_code());
      end
      compared++;
      if (csr_rdata_o !== exp_rdata()) begin
        mismatched++;
        $display("FAIL rnd_rdata[%0d] addr %h: got %h want %h", i, csr_raddr_i, csr_rdata_o, exp_rdata());
      end
      compared++;
      if (csr_mepc_o !== visible().mepc || csr_mtvec_o !== visible().mtvec) begin
        mismatched++;
        $display("FAIL rnd_vec[%0d]: mepc %h/%h mtvec %h/%h", i, csr_mepc_o, visible().mepc,
                 csr_mtvec_o, visible().mtvec);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 0;
    m = reset_state();
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_ecall();
    test_mret_forward();
    test_timer();
    test_priority();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap arbiter, sitting directly upstream of the pipeline controller.
- Prioritises raw exception flags from the MEM stage plus a timer interrupt into one exception code. Outputs that code, mepc and mtvec to the controller, which then flushes and redirects the PC.
- Commits trap side effects (mepc, mcause, mtval, mstatus) on the clock edge.
- Provides a CSR read port for the ID/EX stages and a write port from WB.

Parameters:
- MTVEC_RST, 32'h00000000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.
- MTIMECMP_RST, 64'hFFFFFFFF_FFFFFFFF, reset value of mtimecmp.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-low.
- csr_raddr_i  in  12  CSR read address from ID/EX.
- csr_rdata_o  out  32  combinational read data, forwarded from the same-cycle WB write.
- csr_we_i  in  1  WB CSR write enable.
- csr_waddr_i  in  12  WB CSR write address.
- csr_wdata_i  in  32  WB CSR write data (already RMW-resolved).
- mem_inst_valid_i  in  1  MEM holds a real instruction (not a bubble).
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_badaddr_i  in  32  faulting address, or instruction word for illegal.
- mem_illegal_i, mem_ebreak_i, mem_ecall_i, mem_ld_misalign_i, mem_st_misalign_i, mem_mret_i  in  1 each  raw exception flags.
- excepttype_o  out  32  exception code to the controller; 0 = none.
- csr_mepc_o  out  32  mepc, forwarded from the WB write.
- csr_mtvec_o  out  32  mtvec base with [1:0] = 00, forwarded.

Behaviour:
- Reset (rst = 0, async): all state is cleared except the following.
  - mtvec = MTVEC_RST.
  - mtimecmp = MTIMECMP_RST.
  - excepttype_o is forced to 0 while rst is low.
- CSR map and access rules:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP [12:11] reads 11; other bits read 0.
  - misa 0x301: read-only 0x40000100.
  - mie 0x304: only MTIE bit 7 is writable.
  - mtvec 0x305: direct mode only; [1:0] read 0.
  - mscratch 0x340, mepc 0x341 ([1:0] read 0), mcause 0x342, mtval 0x343: read/write.
  - mip 0x344: read-only; MTIP bit 7.
  - mcycle 0xB00 and mcycleh 0xB80: read/write.
  - mtimecmp 0x7C0 (low) and 0x7C1 (high): read/write.
  - mhartid 0xF14: reads HART_ID.
  - Unmapped addresses read 0 and ignore writes.
- mcycle: 64-bit counter, +1 every cycle with wrap at 2^64. A WB write to one half loads that half; the other half still increments normally, with carry.
- MTIP = (mcycle >= mtimecmp), unsigned 64-bit compare on current register values.
- Interrupt pending: irq = mstatus.MIE & mie.MTIE & MTIP & mem_inst_valid_i.
- excepttype_o (combinational) is 0 when mem_inst_valid_i = 0 and no irq. Otherwise, first match wins:
  1. irq → 0x80000007
  2. illegal → 0x2
  3. ebreak → 0x3
  4. ecall → 0xb
  5. ld_misalign → 0x4
  6. st_misalign → 0x6
  7. mret → 0xa
- Trap commit at the clock edge when excepttype_o is non-zero and not 0xa:
  - mepc ← mem_pc_i.
  - mcause ← excepttype_o.
  - mtval ← mem_badaddr_i for codes 2/4/6, else 0.
  - MPIE ← MIE; MIE ← 0.
- mret commit (code 0xa): MIE ← MPIE; MPIE ← 1. mepc and mcause are unchanged.
- Same-cycle WB write and trap/mret: the WB instruction is older, so its write is applied first, then trap/mret updates overwrite the mepc/mcause/mtval/mstatus fields they touch. WB writes to any other CSR proceed normally.
- Forwarding:
  - csr_mepc_o, csr_mtvec_o and csr_rdata_o return csr_wdata_i (masked per the field rules) when WB writes the matching address in the same cycle.
  - mret therefore uses a just-written mepc, with zero added latency.
- No internal FSM beyond the register state. Trap decision latency is 0 cycles (combinational); state update latency is 1 edge.
- A stall does not suppress reporting. The controller gives exceptions priority over stalls.

Decomposition:
- defines.v: CSR addresses; exception codes, including the existing mret 0xa; mstatus bit indices; RstEnable.
- Sub-module csr_counter: 64-bit mcycle with half-writes, plus the mtimecmp register and the MTIP compare.

Test Plan:
- Reset: drop rst mid-cycle → all outputs immediately 0 and csr_mtvec_o = MTVEC_RST. Release, then read 0x301 → 0x40000100.
- ecall: write mtvec 0x100 and mstatus 0x8, then ecall at pc 0x40 → excepttype_o = 0xb, csr_mtvec_o = 0x100. Next cycle: mepc = 0x40, mcause = 0xb, mstatus reads 0x1880.
- mret with forwarding: WB writes mepc = 0x44 in the same cycle MEM asserts mret → excepttype_o = 0xa, csr_mepc_o = 0x44. Next cycle: mstatus.MIE = 1.
- Timer: mtimecmp = 20, MIE = 1, MTIE = 1, valid instruction with ld_misalign at pc 0x80 once mcycle ≥ 20 → excepttype_o = 0x80000007, mepc = 0x80, mtval = 0.
- Priority: illegal + ecall + st_misalign together, irq masked → 0x2, mtval = mem_badaddr_i. Same flags with mem_inst_valid_i = 0 → 0.
- Counter: write mcycle = 0xFFFFFFFF → mcycleh increments on the next cycle and mcycle wraps to 0.
